// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the memory-port arbiter.
//   NREQ           number of requesters (3)
//   IF, DM, IO     requester index constants (fetch, data, I/O)
//   LOCK_MAX_DEFAULT  default limit on consecutive locked grants
//   lock_state_e   UNLOCKED / LOCKED
//   wrap_inc, idx2onehot, onehot2idx  small index helpers for a 3-way ring
package mem_arb_pkg;

  localparam int NREQ = 3;

  localparam logic [1:0] IF = 2'd0;
  localparam logic [1:0] DM = 2'd1;
  localparam logic [1:0] IO = 2'd2;

  localparam int LOCK_MAX_DEFAULT = 8;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // Next index on the 0 -> 1 -> 2 -> 0 ring; the unused code 3 maps to 0.
  function automatic logic [1:0] wrap_inc(input logic [1:0] idx);
    logic [1:0] nxt;
    case (idx)
      2'd0:    nxt = 2'd1;
      2'd1:    nxt = 2'd2;
      2'd2:    nxt = 2'd0;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction

  function automatic logic [NREQ-1:0] idx2onehot(input logic [1:0] idx);
    logic [NREQ-1:0] oh;
    case (idx)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // Only valid for one-hot or zero input; zero maps to index 0.
  function automatic logic [1:0] onehot2idx(input logic [NREQ-1:0] oh);
    logic [1:0] idx;
    case (oh)
      3'b010:  idx = 2'd1;
      3'b100:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick: purely combinational rotating-priority picker.
//   req  [2:0]  pending requests
//   base [1:0]  index with highest priority; priority rotates upward from it
//   gnt  [2:0]  one-hot grant of the first pending request found, or 0
module rr_pick
  import mem_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      base,
  output logic [NREQ-1:0] gnt
);

  logic [1:0] idx_s;
  logic       found_s;

  // Walk the ring starting at base and take the first pending requester.
  always_comb begin
    gnt     = 3'b000;
    idx_s   = base;
    found_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found_s && req[idx_s]) begin
        gnt     = idx2onehot(idx_s);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
      idx_s = wrap_inc(idx_s);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: three-requester arbiter in front of a single-port RAM,
// round-robin with an optional bounded lock for back-to-back ownership.
//   Clk, reset                 clock, synchronous active-high reset
//   req, we, lock [2:0]        per-requester request / write / lock
//   addrN, wdataN              per-requester address and write data
//   gnt [2:0]                  combinational one-hot grant (access accepted)
//   rvalid [2:0]               registered one-hot read-data-valid
//   rdata                      read data (pass-through of mem_rdata)
//   mem_en, mem_we, mem_addr, mem_wdata   RAM command, muxed from the winner
//   mem_rdata                  RAM read data, one cycle after a read
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   we,
  input  logic [NREQ-1:0]   lock,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W      = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W:0]  LOCK_MAX_C = LOCK_MAX[CNT_W:0];

  lock_state_e       state_r, state_nxt_s;
  logic [1:0]        last_grant_r, last_grant_nxt_s;
  logic [1:0]        owner_r, owner_nxt_s;
  logic [CNT_W-1:0]  count_r, count_nxt_s;
  logic [CNT_W:0]    count_inc_s;
  // After a forced release the former owner may be granted but may not
  // re-lock until some other requester has been granted.
  logic              block_r, block_nxt_s;
  logic [1:0]        block_idx_r, block_idx_nxt_s;

  logic [NREQ-1:0]   rr_gnt_s, gnt_s, rvalid_r;
  logic [1:0]        base_s, rr_idx_s, sel_idx_s;
  logic              owner_hold_s;
  logic              mem_en_s, mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  assign base_s       = wrap_inc(last_grant_r);
  assign rr_idx_s     = onehot2idx(rr_gnt_s);
  assign owner_hold_s = (state_r == LOCKED) && req[owner_r];
  assign count_inc_s  = {1'b0, count_r} + {{CNT_W{1'b0}}, 1'b1};

  rr_pick u_rr_pick (
    .req  (req),
    .base (base_s),
    .gnt  (rr_gnt_s)
  );

  // Grant selection and lock/rotation next-state.
  always_comb begin
    gnt_s            = 3'b000;
    state_nxt_s      = state_r;
    last_grant_nxt_s = last_grant_r;
    owner_nxt_s      = owner_r;
    count_nxt_s      = count_r;
    block_nxt_s      = block_r;
    block_idx_nxt_s  = block_idx_r;
    if (reset) begin
      gnt_s = 3'b000;
    end else if (owner_hold_s) begin
      gnt_s            = idx2onehot(owner_r);
      last_grant_nxt_s = owner_r;
      count_nxt_s      = count_inc_s[CNT_W-1:0];
      if (!lock[owner_r]) begin
        state_nxt_s = UNLOCKED;
        count_nxt_s = {CNT_W{1'b0}};
      end else if (count_inc_s >= LOCK_MAX_C) begin
        state_nxt_s     = UNLOCKED;
        count_nxt_s     = {CNT_W{1'b0}};
        block_nxt_s     = 1'b1;
        block_idx_nxt_s = owner_r;
      end else begin
        state_nxt_s = LOCKED;
      end
    end else begin
      // Owner absent (or never locked): plain round-robin this cycle.
      gnt_s       = rr_gnt_s;
      state_nxt_s = UNLOCKED;
      count_nxt_s = {CNT_W{1'b0}};
      if (rr_gnt_s != 3'b000) begin
        last_grant_nxt_s = rr_idx_s;
        if (block_r && (rr_idx_s == block_idx_r)) begin
          block_nxt_s = 1'b1;
        end else begin
          block_nxt_s = 1'b0;
          if (lock[rr_idx_s]) begin
            if (LOCK_MAX <= 1) begin
              block_nxt_s     = 1'b1;
              block_idx_nxt_s = rr_idx_s;
            end else begin
              state_nxt_s = LOCKED;
              owner_nxt_s = rr_idx_s;
              count_nxt_s = {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_nxt_s = UNLOCKED;
          end
        end
      end else begin
        last_grant_nxt_s = last_grant_r;
      end
    end
  end

  // Lock, rotation and relock-block state registers.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_r      <= UNLOCKED;
      last_grant_r <= IO;
      owner_r      <= IF;
      count_r      <= {CNT_W{1'b0}};
      block_r      <= 1'b0;
      block_idx_r  <= IF;
    end else begin
      state_r      <= state_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      owner_r      <= owner_nxt_s;
      count_r      <= count_nxt_s;
      block_r      <= block_nxt_s;
      block_idx_r  <= block_idx_nxt_s;
    end
  end

  // RAM command mux from the granted requester; all zero when idle.
  always_comb begin
    mem_en_s    = |gnt_s;
    sel_idx_s   = onehot2idx(gnt_s);
    mem_we_s    = 1'b0;
    mem_addr_s  = {ADDR_W{1'b0}};
    mem_wdata_s = {DATA_W{1'b0}};
    if (mem_en_s) begin
      case (sel_idx_s)
        IF: begin
          mem_we_s    = we[0];
          mem_addr_s  = addr0;
          mem_wdata_s = wdata0;
        end
        DM: begin
          mem_we_s    = we[1];
          mem_addr_s  = addr1;
          mem_wdata_s = wdata1;
        end
        IO: begin
          mem_we_s    = we[2];
          mem_addr_s  = addr2;
          mem_wdata_s = wdata2;
        end
        default: begin
          mem_we_s    = 1'b0;
          mem_addr_s  = {ADDR_W{1'b0}};
          mem_wdata_s = {DATA_W{1'b0}};
        end
      endcase
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Read-valid pipeline stage: one cycle after a granted read.
  always_ff @(posedge Clk) begin
    if (reset) begin
      rvalid_r <= 3'b000;
    end else begin
      rvalid_r <= gnt_s & ~we;
    end
  end

  // Gating with reset suppresses a read-valid already in flight when reset hits.
  assign rvalid    = rvalid_r & {NREQ{~reset}};
  assign rdata     = mem_rdata;
  assign gnt       = gnt_s;
  assign mem_en    = mem_en_s;
  assign mem_we    = mem_we_s;
  assign mem_addr  = mem_addr_s;
  assign mem_wdata = mem_wdata_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios with literal expectations followed
// by constrained-random traffic, all checked against a behavioural model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int LMAX = 8;

  logic        Clk, reset;
  logic [2:0]  req, we, lock;
  logic [15:0] addr0, addr1, addr2, wdata0, wdata1, wdata2;
  logic [2:0]  gnt, rvalid;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_we;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .LOCK_MAX(LMAX)) dut (
    .Clk(Clk), .reset(reset), .req(req), .we(we), .lock(lock),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Bench RAM driven by the DUT's memory port.
  logic [15:0] ram  [0:255];
  logic [15:0] mmem [0:255];
  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]  = 16'h0000;
      mmem[i] = 16'h0000;
    end
    mem_rdata = 16'h0000;
  end

  always @(posedge Clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  // Behavioural model: rotation pointer, lock owner/length, relock block.
  int          m_last = 2, m_owner = 0, m_count = 0, m_bidx = 0;
  bit          m_locked = 1'b0, m_block = 1'b0;
  logic [2:0]  exp_rv = 3'b000;
  logic [15:0] exp_rd = 16'h0000;

  always @(negedge Clk) begin
    int          g, c;
    bit          hold;
    logic [2:0]  eg;
    logic [15:0] a [3];
    logic [15:0] d [3];
    a[0] = addr0; a[1] = addr1; a[2] = addr2;
    d[0] = wdata0; d[1] = wdata1; d[2] = wdata2;

    chk("rvalid", {29'd0, rvalid}, reset ? 32'd0 : {29'd0, exp_rv});
    if (!reset && exp_rv != 3'b000) chk("rdata", {16'd0, rdata}, {16'd0, exp_rd});

    g = -1;
    hold = 1'b0;
    if (!reset) begin
      if (m_locked && req[m_owner]) begin
        g = m_owner;
        hold = 1'b1;
      end else begin
        for (int k = 0; k < 3; k++) begin
          c = (m_last + 1 + k) % 3;
          if (g < 0 && req[c]) g = c;
        end
      end
    end
    eg = (g < 0) ? 3'b000 : (3'b001 << g);

    chk("gnt", {29'd0, gnt}, {29'd0, eg});
    chk("mem_en", {31'd0, mem_en}, {31'd0, (g >= 0)});
    chk("mem_we", {31'd0, mem_we}, (g >= 0) ? {31'd0, we[g]} : 32'd0);
    chk("mem_addr", {16'd0, mem_addr}, (g >= 0) ? {16'd0, a[g]} : 32'd0);
    chk("mem_wdata", {16'd0, mem_wdata}, (g >= 0) ? {16'd0, d[g]} : 32'd0);

    exp_rv = 3'b000;
    if (g >= 0) begin
      if (we[g]) begin
        mmem[a[g][7:0]] = d[g];
      end else begin
        exp_rv = eg;
        exp_rd = mmem[a[g][7:0]];
      end
    end

    if (reset) begin
      m_last = 2; m_locked = 1'b0; m_count = 0; m_block = 1'b0;
    end else if (g < 0) begin
      m_locked = 1'b0;
      m_count = 0;
    end else begin
      if (hold) begin
        m_count++;
        if (!lock[g]) begin
          m_locked = 1'b0; m_count = 0;
        end else if (m_count >= LMAX) begin
          m_locked = 1'b0; m_count = 0; m_block = 1'b1; m_bidx = g;
        end
      end else begin
        m_locked = 1'b0; m_count = 0;
        if (!(m_block && g == m_bidx)) begin
          m_block = 1'b0;
          if (lock[g]) begin
            m_locked = 1'b1; m_owner = g; m_count = 1;
          end
        end
      end
      m_last = g;
    end
  end

  task automatic step(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l);
    @(posedge Clk);
    #1;
    req = r; we = w; lock = l;
    #2;
  endtask

  logic [2:0]  seq [4];
  bit          p_valid [3];
  bit          p_we [3];
  bit          p_lock [3];
  bit          lock_mode [3];
  logic [15:0] p_addr [3];
  logic [15:0] p_wdata [3];
  logic [2:0]  gs;

  initial begin
    reset = 1'b1; req = 3'b000; we = 3'b000; lock = 3'b000;
    addr0 = 16'h0010; addr1 = 16'h0011; addr2 = 16'h0012;
    wdata0 = 16'h0000; wdata1 = 16'h0000; wdata2 = 16'h0000;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_gnt", {29'd0, gnt}, 32'd0);
    chk("reset_mem_en", {31'd0, mem_en}, 32'd0);
    reset = 1'b0;

    // Round-robin from reset: 001, 010, 100, 001, rvalid one cycle later.
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;
    for (int k = 0; k < 4; k++) begin
      step(3'b111, 3'b000, 3'b000);
      chk("rr_gnt", {29'd0, gnt}, {29'd0, seq[k]});
      chk("rr_rvalid", {29'd0, rvalid}, (k == 0) ? 32'd0 : {29'd0, seq[k-1]});
    end
    step(3'b000, 3'b000, 3'b000);
    chk("rr_rvalid_last", {29'd0, rvalid}, 32'd1);

    // Write 0xBEEF by requester 1, read it back by requester 0.
    addr1 = 16'h0040; wdata1 = 16'hBEEF;
    step(3'b010, 3'b010, 3'b000);
    chk("wr_gnt", {29'd0, gnt}, 32'd2);
    chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
    chk("wr_mem_addr", {16'd0, mem_addr}, 32'h0040);
    chk("wr_mem_wdata", {16'd0, mem_wdata}, 32'hBEEF);
    addr0 = 16'h0040;
    step(3'b001, 3'b000, 3'b000);
    chk("rd_gnt", {29'd0, gnt}, 32'd1);
    chk("wr_no_rvalid", {29'd0, rvalid}, 32'd0);
    step(3'b000, 3'b000, 3'b000);
    chk("rd_rvalid", {29'd0, rvalid}, 32'd1);
    chk("rd_rdata", {16'd0, rdata}, 32'hBEEF);

    // Requester 1 locked: eight grants, then 100, 001, then 010 again.
    for (int k = 0; k < 8; k++) begin
      step(3'b111, 3'b000, 3'b010);
      chk("lock_run", {29'd0, gnt}, 32'd2);
    end
    step(3'b111, 3'b000, 3'b010);
    chk("lock_after_io", {29'd0, gnt}, 32'd4);
    step(3'b111, 3'b000, 3'b010);
    chk("lock_after_if", {29'd0, gnt}, 32'd1);
    step(3'b111, 3'b000, 3'b010);
    chk("lock_regrant", {29'd0, gnt}, 32'd2);
    step(3'b000, 3'b000, 3'b000);

    // Requester 2 locked, then drops its request while requester 0 waits.
    step(3'b100, 3'b000, 3'b100);
    chk("io_lock", {29'd0, gnt}, 32'd4);
    step(3'b101, 3'b000, 3'b100);
    chk("io_lock_hold", {29'd0, gnt}, 32'd4);
    step(3'b001, 3'b000, 3'b000);
    chk("io_drop_gnt", {29'd0, gnt}, 32'd1);
    step(3'b000, 3'b000, 3'b000);
    chk("io_drop_unlocked", {31'd0, dut.state_r}, {31'd0, UNLOCKED});

    // Reset right after a granted read kills the pending rvalid.
    step(3'b001, 3'b000, 3'b000);
    chk("rst_rd_gnt", {29'd0, gnt}, 32'd1);
    @(posedge Clk); #1;
    reset = 1'b1; req = 3'b000;
    #2;
    chk("rst_rvalid", {29'd0, rvalid}, 32'd0);
    chk("rst_gnt", {29'd0, gnt}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    @(posedge Clk); #3;
    chk("rst_rvalid2", {29'd0, rvalid}, 32'd0);
    @(posedge Clk); #1;
    reset = 1'b0; req = 3'b111;
    #2;
    chk("rst_first_gnt", {29'd0, gnt}, 32'd1);
    step(3'b000, 3'b000, 3'b000);

    // Random traffic obeying the hold-until-granted rule.
    for (int i = 0; i < 3; i++) begin
      p_valid[i] = 1'b0; lock_mode[i] = 1'b0;
    end
    gs = 3'b000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge Clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (gs[i]) p_valid[i] = 1'b0;
        if (!p_valid[i] && $urandom_range(0, 3) != 0) begin
          if ($urandom_range(0, 5) == 0) lock_mode[i] = ~lock_mode[i];
          p_valid[i] = 1'b1;
          p_we[i]    = ($urandom_range(0, 2) == 0);
          p_lock[i]  = lock_mode[i];
          p_addr[i]  = 16'($urandom_range(0, 15));
          p_wdata[i] = 16'($urandom);
        end
      end
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 3; i++) begin
        req[i] = p_valid[i]; we[i] = p_we[i]; lock[i] = p_lock[i];
      end
      addr0 = p_addr[0]; addr1 = p_addr[1]; addr2 = p_addr[2];
      wdata0 = p_wdata[0]; wdata1 = p_wdata[1]; wdata2 = p_wdata[2];
      @(negedge Clk);
      gs = gnt;
    end

    @(posedge Clk); #1;
    req = 3'b000; reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 16, memory address width; DATA_W, 16, memory data width; LOCK_MAX, 8, maximum consecutive locked grants.
REQ-002 Clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 req  input  3  per-requester access request; bit 0 is instruction fetch, bit 1 is data load/store, bit 2 is I/O.
REQ-005 we  input  3  per-requester write enable; 1 = write, 0 = read.
REQ-006 lock  input  3  per-requester lock; requests back-to-back ownership.
REQ-007 addr0, addr1, addr2  input  ADDR_W each  per-requester address.
REQ-008 wdata0, wdata1, wdata2  input  DATA_W each  per-requester write data.
REQ-009 gnt  output  3  one-hot grant; combinational; the access is accepted in the cycle gnt is high.
REQ-010 rvalid  output  3  registered; one-hot read-data-valid.
REQ-011 rdata  output  DATA_W  read data; equals mem_rdata; meaningful only while any rvalid bit is 1.
REQ-012 mem_en, mem_we  output  1 each  single-port RAM enable and write strobe.
REQ-013 mem_addr, mem_wdata  output  ADDR_W, DATA_W  RAM address and write data, muxed from the granted requester.
REQ-014 mem_rdata  input  DATA_W  RAM read data; valid one cycle after a read-enable cycle.

Function
REQ-015 A requester SHALL hold req, we, lock, addr and wdata stable from assertion until the cycle its gnt is 1.
REQ-016 At most one gnt bit SHALL be 1 per cycle; gnt SHALL be 0 for every requester whose req is 0.
REQ-017 Unlocked arbitration SHALL be round-robin: priority starts at (last_grant+1) mod 3 and rotates upward; last_grant updates only on a grant.
REQ-018 In a grant cycle: mem_en=1, mem_we=we[g], mem_addr=addr[g], mem_wdata=wdata[g], where g is the granted index; otherwise mem_en=0 and mem_we=0.
REQ-019 A granted read SHALL set rvalid[g]=1 for exactly the next cycle; a granted write SHALL never produce rvalid.
REQ-020 Throughput SHALL be one access per cycle; back-to-back reads from different requesters SHALL produce back-to-back rvalid with correct one-hot owner.
REQ-021 Lock FSM states SHALL be UNLOCKED and LOCKED(owner, count).
REQ-022 UNLOCKED->LOCKED SHALL occur when the granted requester has lock[g]=1: owner=g, count=1.
REQ-023 In LOCKED, if req[owner]=1, owner SHALL be granted regardless of rotation, and count SHALL increment.
REQ-024 LOCKED->UNLOCKED SHALL occur on any of: req[owner]=0 in a cycle (no grant to owner that cycle, normal round-robin applies); a grant with lock[owner]=0; or a grant that makes count reach LOCK_MAX.
REQ-025 On forced release at LOCK_MAX, last_grant=owner, so the other requesters are ahead in rotation; the former owner SHALL NOT re-lock before one other pending requester is granted.
REQ-026 With no requests: no grant, mem_en=0, last_grant unchanged, and lock state released.

Reset
REQ-027 While reset=1: gnt=0, mem_en=0, mem_we=0, and rvalid=0 in the following cycle, including when a read was granted in the previous cycle.
REQ-028 Reset values: last_grant=2 (requester 0 has highest priority first), lock state=UNLOCKED, count=0.
REQ-029 mem_addr and mem_wdata SHALL be 0 while no grant is active.

Structure
REQ-030 Package mem_arb_pkg SHALL hold: NREQ=3, the requester index constants (IF=0, DM=1, IO=2), the lock-state enum, and the LOCK_MAX default.
REQ-031 The rotating-priority pick SHALL be a sub-module rr_pick: inputs req[2:0] and base index; output one-hot grant; purely combinational.

Verification
REQ-032 After reset, req=3'b111, all reads -> gnt sequence 001, 010, 100, 001; rvalid sequence follows one cycle later.
REQ-033 req1 write (addr 0x0040, wdata 0xBEEF), then req0 read of 0x0040 -> mem_we=1 in the write cycle; rvalid=001 with rdata=0xBEEF, and rvalid[1] is never asserted.
REQ-034 req1 with lock=1 continuously, req0 and req2 also pending -> eight consecutive gnt=010, then gnt=100 and gnt=001 before 010 is granted again.
REQ-035 Requester 2 locked, then its req is dropped for one cycle while req0 is pending -> gnt=001 in that cycle; lock state is UNLOCKED.
REQ-036 Read granted in cycle N, reset asserted in cycle N+1 -> rvalid=0 in cycle N+1 and later; after reset release, first grant goes to requester 0.
